// File: rtl/rv_fetch_pkg.sv
// Shared fetch definitions: reset PC, instruction length encoding and controller states.
package rv_fetch_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT   = 32'h0000_0000;
    localparam int unsigned IMEM_BYTES_DEFAULT = 4096;

    // Halfword opcode bits [1:0] == 2'b11 marks a 32-bit instruction; anything else is RVC.
    localparam logic [1:0] OPC_LEN32 = 2'b11;
    localparam logic [2:0] LEN_C     = 3'd2;
    localparam logic [2:0] LEN_32    = 3'd4;

    typedef enum logic {StBoot, StRun} fetch_state_t;

endpackage

// File: rtl/fetch_len_dec.sv
// Instruction length decode from the low two opcode bits of the first halfword.
module fetch_len_dec
    import rv_fetch_pkg::*;
(
    input  logic [1:0] opc_i,
    output logic       is_c_o,
    output logic [2:0] len_o
);

    always_comb begin
        is_c_o = (opc_i != OPC_LEN32);
        len_o  = is_c_o ? LEN_C : LEN_32;
    end

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Fetch controller for a dual-halfword-port instruction memory; the memory output registers
// serve as the instruction register, so the controller only steers addresses and the read strobe.
module instr_fetch_ctrl
    import rv_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int unsigned IMEM_BYTES = IMEM_BYTES_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_is_c,
    output logic        instr_fault,
    output logic        redirect_misal,
    output logic [31:0] fetch_count,
    output logic [31:0] mem_addr1,
    output logic [31:0] mem_addr2,
    output logic        mem_renable,
    input  logic [15:0] mem_rdata1,
    input  logic [15:0] mem_rdata2
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         vld_q, vld_d;
    logic [31:0]  fetch_count_q;
    logic         misal_q;

    logic         is_c;
    logic [2:0]   len;
    logic         fire;
    logic         renable;
    logic [31:0]  redir_addr;
    logic [31:0]  pc_hi;
    logic [31:0]  imem_lim;

    fetch_len_dec u_len_dec (
        .opc_i  (mem_rdata1[1:0]),
        .is_c_o (is_c),
        .len_o  (len)
    );

    assign fire       = vld_q & instr_ready & ~redirect_valid;
    assign redir_addr = {redirect_pc[31:1], 1'b0};
    assign pc_hi      = pc_q + 32'd2;
    assign imem_lim   = 32'(IMEM_BYTES);

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        vld_d     = vld_q;
        renable   = 1'b0;
        mem_addr1 = pc_q;
        if (redirect_valid) begin
            // Redirect wins in every state, including the boot fetch.
            state_d   = StRun;
            renable   = 1'b1;
            mem_addr1 = redir_addr;
            pc_d      = redir_addr;
            vld_d     = 1'b1;
        end else if (state_q == StBoot) begin
            state_d   = StRun;
            renable   = 1'b1;
            mem_addr1 = RESET_PC;
            pc_d      = RESET_PC;
            vld_d     = 1'b1;
        end else if (fire) begin
            renable   = 1'b1;
            mem_addr1 = pc_q + 32'(len);
            pc_d      = mem_addr1;
            vld_d     = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StBoot;
            pc_q          <= RESET_PC;
            vld_q         <= 1'b0;
            fetch_count_q <= 32'd0;
            misal_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            vld_q   <= vld_d;
            misal_q <= redirect_valid & redirect_pc[0];
            if (fire) begin
                fetch_count_q <= fetch_count_q + 32'd1;
            end
        end
    end

    // The strobe is held low throughout reset so the memory cannot load stale data.
    assign mem_renable    = renable & rst_n;
    assign mem_addr2      = mem_addr1 + 32'd2;

    assign instr_valid    = vld_q;
    assign instr_pc       = pc_q;
    assign instr_is_c     = is_c;
    assign instr          = is_c ? {16'h0000, mem_rdata1} : {mem_rdata2, mem_rdata1};
    assign instr_fault    = vld_q & ((pc_q >= imem_lim) | (~is_c & (pc_hi >= imem_lim)));
    assign redirect_misal = misal_q;
    assign fetch_count    = fetch_count_q;

endmodule
